// File: rtl/reg_bank_4x4.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_4x4
//  Purpose  : Storage stage of the 4x4 register file. Holds four WIDTH-bit
//             registers and presents them in parallel to the read-select
//             multiplexer. Write, swap and clear commands are issued through
//             a start/busy/done handshake sequenced by a two-state FSM.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             start, op           - command strobe and opcode
//                                   (00 nop, 01 write, 10 swap, 11 clear)
//             addr_a, addr_b      - write target / swap operands
//             wr_data             - write data
//             busy, done          - swap in progress / completion pulse
//             valid               - per-register "holds written data" flags
//             q0..q3              - register contents (to mux in0..in3)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_bank_4x4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [1:0]       addr_a,
  input  logic [1:0]       addr_b,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [3:0]       valid,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3
);

  localparam logic [1:0] c_OP_NOP   = 2'b00;
  localparam logic [1:0] c_OP_WRITE = 2'b01;
  localparam logic [1:0] c_OP_SWAP  = 2'b10;
  localparam logic [1:0] c_OP_CLEAR = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SWAP = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  logic [WIDTH-1:0]   r_regs [4];
  logic [3:0]         r_valid;
  logic [WIDTH-1:0]   r_tmp;
  logic               r_tmp_valid;
  logic [1:0]         r_addr_b;
  logic               r_busy;
  logic               r_done;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake outputs. busy is only ever set on the swap
  // accept edge, and done only in cycles that do not set busy, so the two
  // registered flags can never be high together.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          case (op)
            c_OP_WRITE: w_done_nxt = 1'b1;
            c_OP_CLEAR: w_done_nxt = 1'b1;
            c_OP_SWAP: begin
              w_busy_nxt  = 1'b1;
              w_state_nxt = S_SWAP;
            end
            c_OP_NOP: ;
          endcase
        end
      end
      S_SWAP: begin
        // start is deliberately not looked at here: no command queuing.
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Register file datapath. A swap is split over two edges: the first edge
  // parks reg[a] in tmp and copies reg[b] into reg[a]; the second edge writes
  // tmp into the latched b address. With a == b both steps are identities.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= '0;
      end
      r_valid     <= 4'b0000;
      r_tmp       <= '0;
      r_tmp_valid <= 1'b0;
      r_addr_b    <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              c_OP_WRITE: begin
                r_regs[addr_a]  <= wr_data;
                r_valid[addr_a] <= 1'b1;
              end
              c_OP_SWAP: begin
                r_tmp           <= r_regs[addr_a];
                r_tmp_valid     <= r_valid[addr_a];
                r_regs[addr_a]  <= r_regs[addr_b];
                r_valid[addr_a] <= r_valid[addr_b];
                r_addr_b        <= addr_b;
              end
              c_OP_CLEAR: begin
                for (int i = 0; i < 4; i++) begin
                  r_regs[i] <= '0;
                end
                r_valid <= 4'b0000;
              end
              c_OP_NOP: ;
            endcase
          end
        end
        S_SWAP: begin
          r_regs[r_addr_b]  <= r_tmp;
          r_valid[r_addr_b] <= r_tmp_valid;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign valid = r_valid;
  assign q0    = r_regs[0];
  assign q1    = r_regs[1];
  assign q2    = r_regs[2];
  assign q3    = r_regs[3];

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_4x4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_bank_4x4
//  Purpose  : Directed self-checking bench for reg_bank_4x4. Expected values
//             are hand-computed constants; outputs are sampled 1 ns after
//             the rising edge (or mid-cycle for asynchronous reset).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_4x4;

  localparam logic [1:0] c_NOP   = 2'b00;
  localparam logic [1:0] c_WRITE = 2'b01;
  localparam logic [1:0] c_SWAP  = 2'b10;
  localparam logic [1:0] c_CLEAR = 2'b11;

  logic        clk;
  logic        rst;
  logic        r_start;
  logic [1:0]  r_op;
  logic [1:0]  r_addr_a;
  logic [1:0]  r_addr_b;
  logic [3:0]  r_wr_data;
  logic        w_busy;
  logic        w_done;
  logic [3:0]  w_valid;
  logic [3:0]  w_q0, w_q1, w_q2, w_q3;
  logic [15:0] w_qbus;

  int n_checks = 0;
  int n_fail   = 0;

  assign w_qbus = {w_q3, w_q2, w_q1, w_q0};

  reg_bank_4x4 #(.WIDTH(4)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (r_start),
    .op      (r_op),
    .addr_a  (r_addr_a),
    .addr_b  (r_addr_b),
    .wr_data (r_wr_data),
    .busy    (w_busy),
    .done    (w_done),
    .valid   (w_valid),
    .q0      (w_q0),
    .q1      (w_q1),
    .q2      (w_q2),
    .q3      (w_q3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Check all observable outputs in one go.
  task automatic chk_all(input string tag, input logic [15:0] q, input logic [3:0] v,
                         input logic b, input logic d);
    chk({tag, ".q"},     w_qbus,          q);
    chk({tag, ".valid"}, {12'd0, w_valid}, {12'd0, v});
    chk({tag, ".busy"},  {15'd0, w_busy},  {15'd0, b});
    chk({tag, ".done"},  {15'd0, w_done},  {15'd0, d});
  endtask

  task automatic drive(input logic s, input logic [1:0] o, input logic [1:0] a,
                       input logic [1:0] b, input logic [3:0] d);
    @(negedge clk);
    r_start   = s;
    r_op      = o;
    r_addr_a  = a;
    r_addr_b  = b;
    r_wr_data = d;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue a single-cycle command and sample just after its accept edge.
  task automatic cmd(input logic [1:0] o, input logic [1:0] a,
                     input logic [1:0] b, input logic [3:0] d);
    drive(1'b1, o, a, b, d);
    step();
    r_start = 1'b0;
  endtask

  logic [15:0] wr_exp_q [4] = '{16'h0003, 16'h0053, 16'h0A53, 16'hFA53};
  logic [3:0]  wr_exp_v [4] = '{4'h1, 4'h3, 4'h7, 4'hF};
  logic [3:0]  wr_data  [4] = '{4'h3, 4'h5, 4'hA, 4'hF};

  initial begin
    rst = 1'b0; r_start = 1'b0; r_op = c_NOP;
    r_addr_a = 2'd0; r_addr_b = 2'd0; r_wr_data = 4'h0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1 chk_all("reset_async", 16'h0000, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Four back-to-back writes, done high each cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, c_WRITE, 2'(i), 2'd0, wr_data[i]);
      step();
      chk_all($sformatf("write%0d", i), wr_exp_q[i], wr_exp_v[i], 1'b0, 1'b1);
    end
    drive(1'b0, c_NOP, 2'd0, 2'd0, 4'h0);
    step();
    chk_all("write_idle", 16'hFA53, 4'hF, 1'b0, 1'b0);

    // Swap 1<->2 with an ignored write to addr 0 during the SWAP cycle.
    cmd(c_SWAP, 2'd1, 2'd2, 4'h0);
    chk_all("swap12_c1", 16'hFAA3, 4'hF, 1'b1, 1'b0);
    drive(1'b1, c_WRITE, 2'd0, 2'd0, 4'h7);
    step();
    r_start = 1'b0;
    chk_all("swap12_c2", 16'hF5A3, 4'hF, 1'b0, 1'b1);
    step();
    chk_all("swap12_after", 16'hF5A3, 4'hF, 1'b0, 1'b0);

    // Self-swap: unchanged contents, still two cycles.
    cmd(c_SWAP, 2'd3, 2'd3, 4'h0);
    chk_all("swap33_c1", 16'hF5A3, 4'hF, 1'b1, 1'b0);
    step();
    chk_all("swap33_c2", 16'hF5A3, 4'hF, 1'b0, 1'b1);

    // Clear, then nop.
    cmd(c_CLEAR, 2'd0, 2'd0, 4'h0);
    chk_all("clear", 16'h0000, 4'h0, 1'b0, 1'b1);
    cmd(c_WRITE, 2'd1, 2'd0, 4'h9);
    chk_all("write1_9", 16'h0090, 4'h2, 1'b0, 1'b1);
    cmd(c_NOP, 2'd2, 2'd3, 4'h5);
    chk_all("nop", 16'h0090, 4'h2, 1'b0, 1'b0);

    // Swap with unwritten operand moves its valid bit too (0 <-> 2).
    cmd(c_WRITE, 2'd0, 2'd0, 4'h6);
    chk_all("write0_6", 16'h0096, 4'h3, 1'b0, 1'b1);
    cmd(c_SWAP, 2'd0, 2'd2, 4'h0);
    chk_all("swap02_c1", 16'h0090, 4'h2, 1'b1, 1'b0);
    step();
    chk_all("swap02_c2", 16'h0690, 4'h6, 1'b0, 1'b1);

    // Reset in the middle of a swap.
    cmd(c_SWAP, 2'd1, 2'd2, 4'h0);
    chk_all("swap12b_c1", 16'h0660, 4'h6, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all("reset_midswap", 16'h0000, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_all("post_reset_idle", 16'h0000, 4'h0, 1'b0, 1'b0);
    cmd(c_WRITE, 2'd2, 2'd0, 4'hC);
    chk_all("post_reset_write", 16'h0C00, 4'h4, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
